// File: rtl/data_sram_axi_bridge_if.sv
// AXI4 single-beat master bus used by the data SRAM bridge.
// The master modport is the bridge side; slave is the memory/interconnect side.
interface data_sram_axi_bridge_if;
    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready,
        output arid, araddr, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready,
        input  arid, araddr, arlen, arsize, arburst, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );
endinterface

// File: rtl/data_sram_axi_bridge.sv
// CPU data-SRAM style request port to single-beat AXI4 master bridge.
// One transaction outstanding at a time; completion signalled by a data_ok pulse.
module data_sram_axi_bridge #(
    parameter logic [3:0] AXI_ID = 4'd1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        wr,
    input  logic [1:0]  size,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    output logic        addr_ok,
    output logic        data_ok,
    output logic [31:0] rdata,
    output logic        resp_err,
    data_sram_axi_bridge_if.master axi
);

    typedef enum logic [2:0] {
        IDLE,
        AR,
        R,
        AW_W,
        B,
        DONE
    } state_t;

    state_t      state, state_nxt;
    logic        wr_reg;
    logic [1:0]  size_reg;
    logic [31:0] addr_reg;
    logic [31:0] wdata_reg;
    logic [3:0]  wstrb_reg;
    logic        aw_done, w_done;
    logic        arvalid_c, rready_c, awvalid_c, wvalid_c, bready_c;

    logic unused_ok;
    assign unused_ok = &{1'b0, axi.rid, axi.bid, axi.rlast};

    assign axi.awid    = AXI_ID;
    assign axi.awaddr  = addr_reg;
    assign axi.awlen   = '0;
    assign axi.awsize  = {1'b0, size_reg};
    assign axi.awburst = 2'b01;
    assign axi.awvalid = awvalid_c;
    assign axi.wdata   = wdata_reg;
    assign axi.wstrb   = wstrb_reg;
    assign axi.wlast   = 1'b1;
    assign axi.wvalid  = wvalid_c;
    assign axi.bready  = bready_c;
    assign axi.arid    = AXI_ID;
    assign axi.araddr  = addr_reg;
    assign axi.arlen   = '0;
    assign axi.arsize  = {1'b0, size_reg};
    assign axi.arburst = 2'b01;
    assign axi.arvalid = arvalid_c;
    assign axi.rready  = rready_c;

    always_comb begin
        state_nxt = state;
        addr_ok   = 1'b0;
        data_ok   = 1'b0;
        arvalid_c = 1'b0;
        rready_c  = 1'b0;
        awvalid_c = 1'b0;
        wvalid_c  = 1'b0;
        bready_c  = 1'b0;
        case (state)
            IDLE: begin
                addr_ok = req;
                if (req) state_nxt = wr ? AW_W : AR;
            end
            AR: begin
                arvalid_c = 1'b1;
                if (axi.arready) state_nxt = R;
            end
            R: begin
                rready_c = 1'b1;
                if (axi.rvalid) state_nxt = DONE;
            end
            AW_W: begin
                // AW and W channels complete independently; leave once both are done
                awvalid_c = !aw_done;
                wvalid_c  = !w_done;
                if ((aw_done || axi.awready) && (w_done || axi.wready)) state_nxt = B;
            end
            B: begin
                bready_c = 1'b1;
                if (axi.bvalid) state_nxt = DONE;
            end
            DONE: begin
                data_ok   = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            wr_reg    <= 1'b0;
            size_reg  <= '0;
            addr_reg  <= '0;
            wdata_reg <= '0;
            wstrb_reg <= '0;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
            rdata     <= '0;
            resp_err  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && req) begin
                wr_reg    <= wr;
                size_reg  <= size;
                addr_reg  <= addr;
                wdata_reg <= wdata;
                wstrb_reg <= wstrb;
            end
            if (state == AW_W && state_nxt == AW_W) begin
                aw_done <= aw_done || axi.awready;
                w_done  <= w_done || axi.wready;
            end else begin
                aw_done <= 1'b0;
                w_done  <= 1'b0;
            end
            if (state == R && axi.rvalid && !wr_reg) begin
                rdata    <= axi.rdata;
                resp_err <= (axi.rresp != 2'b00);
            end
            if (state == B && axi.bvalid) resp_err <= (axi.bresp != 2'b00);
        end
    end

endmodule
